// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one combinational ALU between two
//             requesters, with a tagged single response channel.
//             Optional grant statistics under macro ALU_ARB_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  input  logic [5:0]         i_req_func,
  input  logic [2*WIDTH-1:0] i_req_a,
  input  logic [2*WIDTH-1:0] i_req_b,
  output logic [2:0]         o_alu_func,
  output logic [WIDTH-1:0]   o_alu_a,
  output logic [WIDTH-1:0]   o_alu_b,
  input  logic [WIDTH-1:0]   i_alu_sum,
  input  logic [WIDTH-1:0]   i_alu_f,
  input  logic               i_alu_zero,
  input  logic               i_alu_overflow,
  input  logic               i_alu_cout,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [WIDTH-1:0]   o_rsp_data,
  output logic [2:0]         o_rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        o_grant_cnt0,
  output logic [15:0]        o_grant_cnt1
`endif
);

  localparam int                 c_CNT_W    = 4;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ALU_LAT - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_EXEC = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               r_last_grant;
  logic               r_id;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_alu_func;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [WIDTH-1:0]   r_rsp_data;
  logic [2:0]         r_rsp_flags;

  logic               w_gid;
  logic               w_grant;
  logic               w_exec_done;
  logic               w_use_sum;
  logic [2:0]         w_sel_func;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;

  // Contention goes to whoever was not served last; otherwise the lone requester.
  assign w_gid = (&i_req_valid) ? ~r_last_grant : i_req_valid[1];

  assign w_grant     = (r_state == c_S_IDLE) && (|i_req_valid);
  assign w_exec_done = (r_state == c_S_EXEC) && (r_cnt == '0);
  assign w_use_sum   = (r_alu_func == 3'b000) || (r_alu_func == 3'b001);

  assign w_sel_func = w_gid ? i_req_func[5:3]        : i_req_func[2:0];
  assign w_sel_a    = w_gid ? i_req_a[WIDTH +: WIDTH] : i_req_a[0 +: WIDTH];
  assign w_sel_b    = w_gid ? i_req_b[WIDTH +: WIDTH] : i_req_b[0 +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: if (|i_req_valid)  w_state_nxt = c_S_EXEC;
      c_S_EXEC: if (r_cnt == '0)   w_state_nxt = c_S_RESP;
      c_S_RESP: if (i_rsp_ready)   w_state_nxt = c_S_IDLE;
      default:                     w_state_nxt = c_S_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 2'b00;
    o_rsp_valid = 1'b0;
    case (r_state)
      c_S_IDLE: if (|i_req_valid) o_req_ready = w_gid ? 2'b10 : 2'b01;
      c_S_RESP: o_rsp_valid = 1'b1;
      default:  o_rsp_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_alu_func   <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_data   <= '0;
      r_rsp_flags  <= '0;
    end else begin
      if (w_grant) begin
        r_alu_func   <= w_sel_func;
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_id         <= w_gid;
        r_last_grant <= w_gid;
        r_cnt        <= c_CNT_LOAD;
      end
      if ((r_state == c_S_EXEC) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      // The ALU is purely combinational; its result is trusted once the count expires.
      if (w_exec_done) begin
        r_rsp_data  <= w_use_sum ? i_alu_sum : i_alu_f;
        r_rsp_flags <= {i_alu_zero, i_alu_overflow, i_alu_cout};
      end
    end
  end

  assign o_alu_func  = r_alu_func;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_rsp_id    = r_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_flags = r_rsp_flags;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_grant_cnt0 <= '0;
      r_grant_cnt1 <= '0;
    end else if (w_grant) begin
      if (!w_gid && (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if ( w_gid && (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign o_grant_cnt0 = r_grant_cnt0;
  assign o_grant_cnt1 = r_grant_cnt1;
`endif

endmodule
`default_nettype wire
